dequant_int8: RTL and testbench

Streaming dequantizer: the inverse of the int8 requantization stage. It accepts 32-bit words carrying four packed uint8 activations, for example from a DDR read DMA. It unpacks the words one byte per cycle, removes the zero point, scales by a 15-bit multiplier and rounds with a right shift. Each output is a signed 24-bit value in the accumulator domain, for the convolution/compare path. Upstream and downstream both use valid/ready handshakes with full backpressure.

---
 rtl/dequant_pkg.sv | 24 ++
 rtl/dequant_int8_byte_unpack.sv | 80 ++++++++
 rtl/dequant_int8.sv | 126 ++++++++++++
 tb/tb_dequant_int8.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dequant_pkg.sv
// Shared widths and types for the int8 dequantizer.
// Optional feature macro: DEQUANT_ROUND_EN (round-half-up instead of floor).
package dequant_pkg;

  localparam int Q_W     = 8;
  localparam int MULT_W  = 15;
  localparam int SHIFT_W = 4;
  localparam int ACC_W   = 24;
  localparam int WORD_W  = 32;
  localparam int LANES   = 4;

  // Scaling parameters captured with each accepted word.
  typedef struct packed {
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
    logic [Q_W-1:0]     zero_point;
  } qparams_t;

  // Index of the final valid lane for a byte count where 0 encodes 4.
  function automatic logic [1:0] last_lane_of(input logic [1:0] nbytes);
    return 2'(nbytes - 2'd1);
  endfunction

endpackage

// File: rtl/dequant_int8_byte_unpack.sv
// Word register and lane sequencer: presents one byte per enabled cycle and
// raises in_ready so the next word can load on the edge the last lane leaves.
//
// Handshake: a word transfers on a clock edge where in_valid & in_ready are
// both high; in_valid must then hold the word stable until that edge.
module byte_unpack
  import dequant_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [1:0]        in_nbytes,
  input  logic              in_last,
  input  qparams_t          in_params,
  output logic              byte_valid,
  output logic [Q_W-1:0]    byte_data,
  output logic              byte_last,
  output qparams_t          byte_params
);

  logic [WORD_W-1:0] word;
  logic [1:0]        lane;
  logic [1:0]        last_lane;
  logic              word_last;
  logic              full;
  logic              rst_released;
  qparams_t          params;

  logic at_last_lane;
  logic accept;

  // Readiness: empty, or the final lane leaves on this edge.
  always_comb begin
    at_last_lane = (lane == last_lane);
    in_ready     = rst_released & en & (~full | at_last_lane);
    accept       = in_valid & in_ready;
  end

  // Hold in_ready low until the first edge after reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_released <= 1'b0;
    else        rst_released <= 1'b1;
  end

  // Load a new word or step through the lanes of the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word      <= '0;
      lane      <= '0;
      last_lane <= '0;
      word_last <= 1'b0;
      full      <= 1'b0;
      params    <= '0;
    end else if (en) begin
      if (accept) begin
        word      <= in_data;
        lane      <= '0;
        last_lane <= last_lane_of(in_nbytes);
        word_last <= in_last;
        full      <= 1'b1;
        params    <= in_params;
      end else if (full) begin
        if (at_last_lane) full <= 1'b0;
        else              lane <= lane + 2'd1;
      end
    end
  end

  // Current lane presented to the arithmetic stages.
  always_comb begin
    byte_valid  = full;
    byte_data   = word[{lane, 3'b000} +: Q_W];
    byte_last   = word_last & at_last_lane;
    byte_params = params;
  end

endmodule

// File: rtl/dequant_int8.sv
// Streaming int8 dequantizer: unpack bytes, subtract zero point, scale, shift.
// Optional feature macro: DEQUANT_ROUND_EN selects round-half-up; otherwise
// the shift truncates toward minus infinity. Latency is the same either way.
//
// Handshake: each side transfers on an edge where valid & ready are high;
// a raised valid holds its data stable until the transfer edge. The whole
// pipeline advances together on en = ~out_valid | out_ready.
module dequant_int8
  import dequant_pkg::*;
(
  input  logic               sclk,
  input  logic               s_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [1:0]         in_nbytes,
  input  logic               in_last,
  input  logic [MULT_W-1:0]  mult,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [Q_W-1:0]     zero_point,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_last
);

  logic     en;
  qparams_t in_params;
  logic     byte_valid;
  logic [Q_W-1:0] byte_data;
  logic     byte_last;
  qparams_t byte_params;

  // Stall-all enable and parameter bundling.
  always_comb begin
    en        = ~out_valid | out_ready;
    in_params = '{mult: mult, shift: shift, zero_point: zero_point};
  end

  byte_unpack u_unpack (
    .clk         (sclk),
    .rst_n       (s_rst_n),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_nbytes   (in_nbytes),
    .in_last     (in_last),
    .in_params   (in_params),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_last   (byte_last),
    .byte_params (byte_params)
  );

  // Stage B arithmetic: 9-bit difference times unsigned multiplier.
  logic signed [8:0]  diff;
  logic signed [24:0] diff_x;
  logic signed [24:0] mult_x;
  logic signed [24:0] prod;

  always_comb begin
    diff   = $signed({1'b0, byte_data}) - $signed({1'b0, byte_params.zero_point});
    diff_x = {{16{diff[8]}}, diff};
    mult_x = $signed({10'b0, byte_params.mult});
    prod   = diff_x * mult_x;
  end

  logic                   b_valid;
  logic signed [ACC_W-1:0] b_prod;
  logic [SHIFT_W-1:0]     b_shift;
  logic                   b_last;

  // Stage B register: product plus the shift that belongs to it.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      b_valid <= 1'b0;
      b_prod  <= '0;
      b_shift <= '0;
      b_last  <= 1'b0;
    end else if (en) begin
      b_valid <= byte_valid;
      if (byte_valid) begin
        b_prod  <= prod[ACC_W-1:0];
        b_shift <= byte_params.shift;
        b_last  <= byte_last;
      end
    end
  end

  // Stage C arithmetic: optional half-LSB bias, then arithmetic shift in 25 bits.
  logic signed [24:0] p_x;
  logic signed [24:0] shifted;
`ifdef DEQUANT_ROUND_EN
  logic signed [24:0] bias;
  logic signed [24:0] biased;
  always_comb begin
    p_x  = {b_prod[ACC_W-1], b_prod};
    bias = '0;
    if (b_shift != '0) bias = 25'sd1 <<< (b_shift - 4'd1);
    biased  = p_x + bias;
    shifted = biased >>> b_shift;
  end
`else
  always_comb begin
    p_x     = {b_prod[ACC_W-1], b_prod};
    shifted = p_x >>> b_shift;
  end
`endif

  // Stage C register: the output sample, held while downstream stalls.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= b_valid;
      if (b_valid) begin
        out_data <= shifted[ACC_W-1:0];
        out_last <= b_last;
      end
    end
  end

endmodule

// File: tb/tb_dequant_int8.sv
// Testbench for dequant_int8: directed corner values, a randomized stream
// with backpressure and a mid-stream reset, checked against an arithmetic
// reference model. Honours DEQUANT_ROUND_EN like the design.
module tb_dequant_int8;

  logic        sclk;
  logic        s_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_nbytes;
  logic        in_last;
  logic [14:0] mult;
  logic [3:0]  shift;
  logic [7:0]  zero_point;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_last;

  int n_vec = 0;
  int n_err = 0;

  // Expected {last, data} of every sample still to come out.
  logic [24:0] exp_q[$];

  dequant_int8 dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_nbytes  (in_nbytes),
    .in_last    (in_last),
    .mult       (mult),
    .shift      (shift),
    .zero_point (zero_point),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  // ---------------- clock / reset ----------------
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor(v / 2^s) for signed v.
  function automatic longint floor_shift(input longint v, input int s);
    longint d;
    d = longint'(1) << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic longint ref_sample(input int q, input int zp, input int m, input int s);
    longint p;
    p = longint'(q - zp) * longint'(m);
`ifdef DEQUANT_ROUND_EN
    if (s > 0) p = p + (longint'(1) << (s - 1));
`endif
    return floor_shift(p, s);
  endfunction

  task automatic model_push(input logic [31:0] d, input logic [1:0] nb, input logic lst,
                            input logic [14:0] m, input logic [3:0] s, input logic [7:0] z);
    int n;
    longint y;
    logic [23:0] y24;
    n = (nb == 2'd0) ? 4 : int'(nb);
    for (int k = 0; k < n; k++) begin
      y   = ref_sample(int'(d[8*k +: 8]), int'(z), int'(m), int'(s));
      y24 = y[23:0];
      exp_q.push_back({lst && (k == n - 1), y24});
    end
  endtask

  // Scoreboard: model on accepted words, compare transfers, watch stalls.
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data;
  logic        prev_last;

  always @(negedge sclk) begin
    logic [24:0] e;
    if (!s_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready)
        model_push(in_data, in_nbytes, in_last, mult, shift, zero_point);
      if (prev_stall) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_data", {8'b0, out_data}, {8'b0, prev_data});
        check("stall_last", {31'b0, out_last}, {31'b0, prev_last});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {8'b0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {8'b0, out_data}, {8'b0, e[23:0]});
          check("sb_last", {31'b0, out_last}, {31'b0, e[24]});
        end
      end
      if (out_valid && !out_ready)
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] d, input logic [1:0] nb, input logic lst,
                      input logic [14:0] m, input logic [3:0] s, input logic [7:0] z);
    int k;
    @(posedge sclk); #1;
    in_data = d; in_nbytes = nb; in_last = lst;
    mult = m; shift = s; zero_point = z;
    in_valid = 1'b1;
    k = 0;
    @(negedge sclk);
    while (!in_ready && k < 50) begin
      @(negedge sclk);
      k++;
    end
    check("send_ready", {31'b0, in_ready}, 32'd1);
    @(posedge sclk); #1;
    in_valid = 1'b0;
  endtask

  // Sample at the next falling edge and compare against a literal result.
  task automatic expect_out(input string tag, input int y, input logic lst);
    logic [23:0] y24;
    y24 = 24'(y);
    @(negedge sclk);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, {8'b0, out_data}, {8'b0, y24});
    check({tag, "_last"}, {31'b0, out_last}, {31'b0, lst});
  endtask

  task automatic expect_idle(input string tag);
    @(negedge sclk);
    check(tag, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic rand_word();
    in_data    = $urandom;
    in_nbytes  = 2'($urandom_range(0, 3));
    in_last    = ($urandom_range(0, 3) == 0);
    mult       = 15'($urandom);
    shift      = 4'($urandom_range(0, 15));
    zero_point = 8'($urandom);
  endtask

  // Random stream with random valid/ready; out_ready forced low in a window.
  task automatic rand_stream(input int cycles, input int hold_lo, input int hold_hi);
    logic fire;
    for (int c = 0; c < cycles; c++) begin
      @(negedge sclk);
      fire = in_valid && in_ready;
      @(posedge sclk); #1;
      out_ready = (c >= hold_lo && c < hold_hi) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (fire || !in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          rand_word();
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    int k;
    @(negedge sclk);
    fork_wait: begin
      @(posedge sclk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 200) begin
      @(negedge sclk);
      k++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- directed and random steps ----------------
  initial begin
    int y_a, y_b, y_c;
    s_rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_nbytes = '0; in_last = 1'b0;
    mult = '0; shift = '0; zero_point = '0; out_ready = 1'b1;

    repeat (3) @(posedge sclk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {8'b0, out_data}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", {31'b0, in_ready}, 32'd0);
    @(posedge sclk); #1;
    check("rel_in_ready_after_edge", {31'b0, in_ready}, 32'd1);

    // Full word, four equal lanes: 72 * 16384 >> 4 = 73728, latency 2.
    send(32'hC8C8_C8C8, 2'd0, 1'b0, 15'd16384, 4'd4, 8'd128);
    expect_idle("lat_t0");
    expect_idle("lat_t1");
    for (int k = 0; k < 4; k++) expect_out("full_word", 73728, 1'b0);
    expect_idle("full_word_end");

    // Two-byte final word: rounding vs floor on an odd value, out_last on lane1.
`ifdef DEQUANT_ROUND_EN
    y_a = 2; y_c = -1;
`else
    y_a = 1; y_c = -2;
`endif
    send(32'h0000_0003, 2'd2, 1'b1, 15'd1, 4'd1, 8'd0);
    @(negedge sclk);
    check("partial_ready_lane0", {31'b0, in_ready}, 32'd0);
    @(negedge sclk);
    check("partial_ready_lane1", {31'b0, in_ready}, 32'd1);
    expect_out("partial0", y_a, 1'b0);
    expect_out("partial1", 0, 1'b1);
    expect_idle("partial_count");

    // Negative odd product: round-half-up gives -1, floor gives -2.
    send(32'h0000_0003, 2'd1, 1'b1, 15'd1, 4'd1, 8'd6);
    expect_idle("neg_t0");
    expect_idle("neg_t1");
    expect_out("neg_round", y_c, 1'b1);

    // Extremes of the product range with shift 0.
    y_b = 8355585;
    send(32'h0000_0000, 2'd1, 1'b0, 15'd32767, 4'd0, 8'd255);
    expect_idle("min_t0");
    expect_idle("min_t1");
    expect_out("min_prod", -y_b, 1'b0);
    send(32'h0000_00FF, 2'd1, 1'b0, 15'd32767, 4'd0, 8'd0);
    expect_idle("max_t0");
    expect_idle("max_t1");
    expect_out("max_prod", y_b, 1'b0);
    repeat (3) @(posedge sclk);

    // Random stream with a five-cycle out_ready hold.
    rand_stream(300, 100, 105);
    drain();

    // Reset in the middle of a busy stream.
    rand_stream(60, 1000, 1000);
    @(posedge sclk); #1;
    s_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    s_rst_n = 1'b1;
    @(posedge sclk); #1;
    check("midrst_ready_back", {31'b0, in_ready}, 32'd1);
    check("midrst_still_empty", {31'b0, out_valid}, 32'd0);

    // Fresh stream after reset.
    rand_stream(300, 150, 155);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
